// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receive and transmit blocks: receiver
// state encoding, data width and the clocks-per-bit divisor calculation.
package rs232_pkg;

  localparam int RS232_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rs232_state_t;

  // Rounded clocks-per-bit, so a baud rate that does not divide the clock
  // evenly lands on the nearest whole divisor instead of always truncating.
  function automatic int rs232_divisor(input longint clock_freq, input longint baud_rate);
    return int'((clock_freq + baud_rate / 2) / baud_rate);
  endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for asynchronous pin inputs. Both flops preset to 1
// so an idle-high serial line never looks like a start edge out of reset.
module rs232_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  // Shift the pin through two flops; the first may go metastable, the second
  // gives the rest of the design a clean, clock-aligned copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/rs232_to_axis.sv
// RS-232 8N1 receiver. Oversamples the synchronized rxd line with a
// clocks-per-bit counter, assembles bytes LSB first and hands them to a
// one-entry valid/ready output buffer. rtsn_pin tells the peer when the
// buffer is empty.
module rs232_to_axis
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready,
  output logic       ferror,
  output logic       overrun,
  input  logic       rxd_pin,
  output logic       rtsn_pin
);

  localparam int DIVISOR = rs232_divisor(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 2;
  localparam int IDX_W   = $clog2(RS232_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RS232_DATA_BITS - 1);

  // Too few clocks per bit leaves no room for mid-bit sampling.
  generate
    if (DIVISOR < 4) begin : g_bad_divisor
      $error("rs232_to_axis: DIVISOR %0d is below the minimum of 4", DIVISOR);
    end
  endgenerate

  logic                       rxd_s;
  rs232_state_t               state;
  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic [RS232_DATA_BITS-1:0] shift;

  logic stop_tick;
  logic good_stop;
  logic bad_stop;
  logic drain;

  rs232_sync u_rxd_sync (
    .clock (clock),
    .reset (reset),
    .din   (rxd_pin),
    .dout  (rxd_s)
  );

  assign stop_tick = (state == STOP) && (cnt == '0);
  assign good_stop = stop_tick && rxd_s;
  assign bad_stop  = stop_tick && !rxd_s;
  assign drain     = ovalid && oready;

  // Receive state machine: half-period delay from the falling edge lands
  // every later sample near mid-bit; BREAK holds off re-triggering until a
  // held-low line returns high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            cnt   <= CNT_HALF;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rxd_s) begin
            cnt   <= CNT_FULL;
            idx   <= '0;
            state <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift <= {rxd_s, shift[RS232_DATA_BITS-1:1]};
            cnt   <= CNT_FULL;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rxd_s) begin
            state <= IDLE;
          end else begin
            state <= BREAK;
          end
        end
        BREAK: begin
          if (rxd_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One-entry output buffer and status flags. A finished byte is accepted
  // when the buffer is empty or being drained this very cycle; otherwise it
  // is dropped and overrun pulses. rtsn_pin follows ovalid one cycle late.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      odata    <= '0;
      ovalid   <= 1'b0;
      ferror   <= 1'b0;
      overrun  <= 1'b0;
      rtsn_pin <= 1'b1;
    end else begin
      ferror   <= bad_stop;
      overrun  <= good_stop && ovalid && !oready;
      rtsn_pin <= ovalid;
      if (good_stop && (!ovalid || oready)) begin
        odata  <= shift;
        ovalid <= 1'b1;
      end else if (drain) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs232_to_axis.sv
// Bench for rs232_to_axis at 16 clocks per bit. Stimulus pushes expected
// bytes into a scoreboard queue; a negedge monitor pops and compares on
// every handshake, and also counts ferror/overrun cycles.
module tb_rs232_to_axis;

  localparam int CLK_FREQ = 16000000;
  localparam int BAUD     = 1000000;
  localparam int BIT_CLKS = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] odata;
  logic       ovalid;
  logic       oready;
  logic       ferror;
  logic       overrun;
  logic       rxd_pin;
  logic       rtsn_pin;

  int         compared     = 0;
  int         mismatched   = 0;
  int         ferrorCount  = 0;
  int         overrunCount = 0;
  logic [7:0] sb[$];
  logic [7:0] monExp;

  // Free-running 100 MHz-style bench clock.
  always #5 clock = ~clock;

  rs232_to_axis #(
    .CLOCK_FREQ (CLK_FREQ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .odata    (odata),
    .ovalid   (ovalid),
    .oready   (oready),
    .ferror   (ferror),
    .overrun  (overrun),
    .rxd_pin  (rxd_pin),
    .rtsn_pin (rtsn_pin)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: away from the active edge, every ovalid&&oready cycle is a
  // transfer at the coming edge, so pop the scoreboard and compare.
  always @(negedge clock) begin
    if (!reset) begin
      if (ferror) ferrorCount++;
      if (overrun) overrunCount++;
      if (ovalid && oready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected beat: got 0x%0h, expected no beat", odata);
        end else begin
          monExp = sb.pop_front();
          checkOutput("beat data", 32'(odata), 32'(monExp));
        end
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one 10-bit frame, one edge per loop pass. Optional hooks raise
  // oready or pulse reset at a chosen edge, and check ovalid latency around
  // the stop sample (edge 155 counting the start-bit edge as 0).
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit checkLat,
                               input int readyEdge, input int rstOnEdge, input int rstOffEdge);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int e = 0; e < 10 * BIT_CLKS; e++) begin
      @(posedge clock);
      #1;
      if (e % BIT_CLKS == 0) rxd_pin = frame[4'(e / BIT_CLKS)];
      if (e == readyEdge) oready = 1'b1;
      if (e == rstOnEdge) reset = 1'b1;
      if (e == rstOffEdge) reset = 1'b0;
      if (rstOnEdge >= 0 && e == rstOnEdge + 2) begin
        checkOutput("odata in reset", 32'(odata), 32'h00);
        checkOutput("ovalid in reset", 32'(ovalid), 32'd0);
        checkOutput("ferror in reset", 32'(ferror), 32'd0);
        checkOutput("overrun in reset", 32'(overrun), 32'd0);
        checkOutput("rtsn_pin in reset", 32'(rtsn_pin), 32'd1);
      end
      if (checkLat && e == 154) checkOutput("ovalid before stop sample", 32'(ovalid), 32'd0);
      if (checkLat && e == 155) checkOutput("ovalid after stop sample", 32'(ovalid), 32'd1);
    end
  endtask

  initial begin
    reset   = 1'b1;
    oready  = 1'b1;
    rxd_pin = 1'b1;
    idleCycles(3);
    checkOutput("reset odata", 32'(odata), 32'h00);
    checkOutput("reset ovalid", 32'(ovalid), 32'd0);
    checkOutput("reset ferror", 32'(ferror), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    checkOutput("reset rtsn_pin", 32'(rtsn_pin), 32'd1);
    reset = 1'b0;
    idleCycles(4);
    checkOutput("rtsn_pin empty", 32'(rtsn_pin), 32'd0);

    $display("[TB] back-to-back 0x55, 0xA3");
    ferrorCount = 0; overrunCount = 0;
    sb.push_back(8'h55);
    applyStimulus(8'h55, 1'b1, 1'b1, -1, -1, -1);
    sb.push_back(8'hA3);
    applyStimulus(8'hA3, 1'b1, 1'b1, -1, -1, -1);
    idleCycles(20);
    checkOutput("t1 pending beats", 32'(sb.size()), 32'd0);
    checkOutput("t1 ferror count", 32'(ferrorCount), 32'd0);
    checkOutput("t1 overrun count", 32'(overrunCount), 32'd0);

    $display("[TB] 5-clock glitch then 0x5A");
    ferrorCount = 0; overrunCount = 0;
    @(posedge clock); #1; rxd_pin = 1'b0;
    repeat (5) @(posedge clock);
    #1; rxd_pin = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    sb.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1, 1'b1, -1, -1, -1);
    idleCycles(20);
    checkOutput("t2 pending beats", 32'(sb.size()), 32'd0);
    checkOutput("t2 ferror count", 32'(ferrorCount), 32'd0);

    $display("[TB] framing error, held break, then 0x81");
    ferrorCount = 0; overrunCount = 0;
    applyStimulus(8'h3C, 1'b0, 1'b0, -1, -1, -1);
    idleCycles(40 * BIT_CLKS);
    rxd_pin = 1'b1;
    idleCycles(2 * BIT_CLKS);
    sb.push_back(8'h81);
    applyStimulus(8'h81, 1'b1, 1'b1, -1, -1, -1);
    idleCycles(20);
    checkOutput("t3 ferror count", 32'(ferrorCount), 32'd1);
    checkOutput("t3 overrun count", 32'(overrunCount), 32'd0);
    checkOutput("t3 pending beats", 32'(sb.size()), 32'd0);

    $display("[TB] stalled consumer, 0x11 then 0x22");
    ferrorCount = 0; overrunCount = 0;
    oready = 1'b0;
    sb.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 1'b0, -1, -1, -1);
    applyStimulus(8'h22, 1'b1, 1'b0, -1, -1, -1);
    idleCycles(10);
    checkOutput("t4 held odata", 32'(odata), 32'h11);
    checkOutput("t4 held ovalid", 32'(ovalid), 32'd1);
    checkOutput("t4 rtsn_pin full", 32'(rtsn_pin), 32'd1);
    checkOutput("t4 overrun count", 32'(overrunCount), 32'd1);
    oready = 1'b1;
    idleCycles(3);
    checkOutput("t4 ovalid after drain", 32'(ovalid), 32'd0);
    checkOutput("t4 pending beats", 32'(sb.size()), 32'd0);

    $display("[TB] drain in the same cycle as the next stop sample");
    ferrorCount = 0; overrunCount = 0;
    oready = 1'b0;
    sb.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 1'b0, -1, -1, -1);
    sb.push_back(8'h22);
    applyStimulus(8'h22, 1'b1, 1'b0, 154, -1, -1);
    idleCycles(10);
    checkOutput("t5 overrun count", 32'(overrunCount), 32'd0);
    checkOutput("t5 pending beats", 32'(sb.size()), 32'd0);
    checkOutput("t5 last odata", 32'(odata), 32'h22);

    $display("[TB] reset during 0xF0, then 0x0F");
    ferrorCount = 0; overrunCount = 0;
    applyStimulus(8'hF0, 1'b1, 1'b0, -1, 84, 90);
    idleCycles(10);
    sb.push_back(8'h0F);
    applyStimulus(8'h0F, 1'b1, 1'b1, -1, -1, -1);
    idleCycles(20);
    checkOutput("t6 pending beats", 32'(sb.size()), 32'd0);
    checkOutput("t6 ferror count", 32'(ferrorCount), 32'd0);
    checkOutput("t6 overrun count", 32'(overrunCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
